// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns: one 32-bit column per cycle, valid/ready on both sides, one block in flight.
// Define MIX_COLUMNS_INV_EN to add the inv port and the InvMixColumns matrix.
module mix_columns_seq #(
  parameter logic [7:0] POLY  = 8'h1B,
  parameter int         NCOLS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
`ifdef MIX_COLUMNS_INV_EN
  input  logic         inv,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [1:0] LAST_COL = 2'(NCOLS - 1);

  state_t       state_q, state_d;
  logic [1:0]   col_cnt_q, col_cnt_d;
  logic [127:0] data_q, data_d;
  logic         accept;
  logic [31:0]  col_sel;
  logic [31:0]  col_mix;
`ifdef MIX_COLUMNS_INV_EN
  logic         inv_q, inv_d;
`endif

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? POLY : 8'h00);
  endfunction

  function automatic logic [31:0] mix_fwd(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

`ifdef MIX_COLUMNS_INV_EN
  function automatic logic [31:0] mix_inv(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x1, x2, x3;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x1    = xt(a[i]);
      x2    = xt(x1);
      x3    = xt(x2);
      m9[i] = x3 ^ a[i];
      mb[i] = x3 ^ x1 ^ a[i];
      md[i] = x3 ^ x2 ^ a[i];
      me[i] = x3 ^ x2 ^ x1;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction
`endif

  // NOTE: all state uses non-blocking assignments and the async reset clears every flop, including the data register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      col_cnt_q <= 2'd0;
      data_q    <= 128'd0;
`ifdef MIX_COLUMNS_INV_EN
      inv_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      col_cnt_q <= col_cnt_d;
      data_q    <= data_d;
`ifdef MIX_COLUMNS_INV_EN
      inv_q     <= inv_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = BUSY;
      BUSY: if (col_cnt_q == LAST_COL) state_d = DONE;
      DONE: if (out_ready) state_d = in_valid ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    out_valid = (state_q == DONE);
  end

  assign accept   = in_valid && in_ready;
  assign out_data = data_q;

  // Single column datapath shared by all four columns through this mux.
  always_comb begin
    col_sel = 32'd0;
    unique case (col_cnt_q)
      2'd0: col_sel = data_q[127:96];
      2'd1: col_sel = data_q[95:64];
      2'd2: col_sel = data_q[63:32];
      2'd3: col_sel = data_q[31:0];
      default: col_sel = 32'd0;
    endcase
  end

`ifdef MIX_COLUMNS_INV_EN
  assign col_mix = inv_q ? mix_inv(col_sel) : mix_fwd(col_sel);
`else
  assign col_mix = mix_fwd(col_sel);
`endif

  always_comb begin
    data_d    = data_q;
    col_cnt_d = col_cnt_q;
`ifdef MIX_COLUMNS_INV_EN
    inv_d     = inv_q;
`endif
    if (accept) begin
      data_d    = in_data;
      col_cnt_d = 2'd0;
`ifdef MIX_COLUMNS_INV_EN
      inv_d     = inv;
`endif
    end else if (state_q == BUSY) begin
      col_cnt_d = col_cnt_q + 2'd1;
      unique case (col_cnt_q)
        2'd0: data_d[127:96] = col_mix;
        2'd1: data_d[95:64]  = col_mix;
        2'd2: data_d[63:32]  = col_mix;
        2'd3: data_d[31:0]   = col_mix;
        default: data_d = data_q;
      endcase
    end
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Self-checking bench for mix_columns_seq: directed FIPS-197 vectors plus random blocks against a GF(2^8) model.
module tb_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         inv = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;

  int n_cmp = 0;
  int n_err = 0;
  logic [127:0] exp_q [$];

  always #5 clk = ~clk;

  mix_columns_seq dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
`ifdef MIX_COLUMNS_INV_EN
    .inv      (inv),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [127:0] mix_model(input logic [127:0] s, input logic iv);
    logic [7:0]   base [4];
    logic [7:0]   acc;
    logic [127:0] r = '0;
    if (iv) base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else    base = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(s[127-8*(4*c+j) -: 8], base[(j - row + 4) % 4]);
        r[127-8*(4*c+row) -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a block at a negedge, wait for in_ready, push its expectation, return #1 after the accept edge.
  task automatic send(input logic [127:0] d, input logic [127:0] exp, input logic iv);
    int waits = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    inv      = iv;
    while (!in_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    check("send_ready", {127'd0, in_ready}, 128'd1);
    exp_q.push_back(exp);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid, compare against the scoreboard, accept for one edge.
  task automatic recv(input string tag);
    int waits = 0;
    logic [127:0] exp;
    while (!out_valid && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    check({tag, "_valid"}, {127'd0, out_valid}, 128'd1);
    check({tag, "_sb_nonempty"}, {127'd0, exp_q.size() > 0}, 128'd1);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 128'd0;
    check(tag, out_data, exp);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] a_in, b_in, hold_val;
    int cnt;

    // Reset state
    #1;
    check("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("rst_out_data", out_data, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("rst_in_ready", {127'd0, in_ready}, 128'd1);

    // Single FIPS-197 column, latency of four BUSY cycles
    send({32'hd4bf5d30, 96'd0}, {32'h046681e5, 96'd0}, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("lat_busy_valid_%0d", i), {127'd0, out_valid}, 128'd0);
      check($sformatf("lat_busy_ready_%0d", i), {127'd0, in_ready}, 128'd0);
    end
    @(negedge clk);
    check("lat_done_valid", {127'd0, out_valid}, 128'd1);
    recv("fips_col");

    // Full FIPS-197 state
    send(128'hdb135345_f20a225c_01010101_c6c6c6c6,
         128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b0);
    recv("fips_state");

    // Back-to-back: second block accepted on the edge the first is delivered
    a_in = rnd128();
    b_in = rnd128();
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = a_in;
    check("b2b_ready_a", {127'd0, in_ready}, 128'd1);
    exp_q.push_back(mix_model(a_in, 1'b0));
    @(posedge clk);
    @(negedge clk);
    in_data = b_in;
    exp_q.push_back(mix_model(b_in, 1'b0));
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("b2b_ready_in_done", {127'd0, in_ready}, 128'd1);
    check("b2b_block_a", out_data, exp_q.pop_front());
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_busy_valid", {127'd0, out_valid}, 128'd0);
    check("b2b_busy_ready", {127'd0, in_ready}, 128'd0);
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("b2b_latency", 128'(cnt), 128'd4);
    check("b2b_block_b", out_data, exp_q.pop_front());
    @(negedge clk);
    out_ready = 1'b0;

    // Backpressure: hold in DONE for 10 cycles with a competing input ignored
    send(rnd128(), 128'd0, 1'b0);
    exp_q.pop_back();
    a_in = in_data;
    exp_q.push_back(mix_model(a_in, 1'b0));
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    hold_val = exp_q[0];
    in_valid = 1'b1;
    in_data  = rnd128();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("bp_data_%0d", i), out_data, hold_val);
      check($sformatf("bp_ready_%0d", i), {127'd0, in_ready}, 128'd0);
    end
    in_valid = 1'b0;
    recv("bp_release");
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("bp_single_%0d", i), {127'd0, out_valid}, 128'd0);
    end
    out_ready = 1'b0;

    // Reset while processing column 2 discards the block
    send(rnd128(), 128'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", {127'd0, out_valid}, 128'd0);
    check("midrst_out_data", out_data, 128'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    a_in = rnd128();
    send(a_in, mix_model(a_in, 1'b0), 1'b0);
    recv("after_rst");

    for (int i = 0; i < 3; i++) begin
      a_in = rnd128();
      send(a_in, mix_model(a_in, 1'b0), 1'b0);
      recv($sformatf("rand_fwd_%0d", i));
    end

`ifdef MIX_COLUMNS_INV_EN
    // Inverse: FIPS state round-trip, inv changed mid-block must not matter
    send(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6,
         128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b1);
    inv = 1'b0;
    recv("inv_fips_state");
    for (int i = 0; i < 2; i++) begin
      a_in = rnd128();
      send(a_in, mix_model(a_in, 1'b1), 1'b1);
      recv($sformatf("rand_inv_%0d", i));
    end
`endif

    check("sb_empty", 128'(exp_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
